// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 16x-oversampling UART receiver.
// The line is synchronised, a start edge is qualified at mid-bit, and each
// data bit is sampled at its mid-point and shifted in LSB-first. The result
// is reported with a one-cycle rx_valid strobe, or with a frame_err strobe
// when the stop bit is low.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit between data
// and stop, with a parity_odd select input and a parity_err strobe output.
module uart_rx_oversampled #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 tick,
  input  logic                 rx,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
  output logic                 parity_err,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 rx_s;
  logic [2:0]           state_q, state_d;
  logic [3:0]           os_cnt_q, os_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  assign rx_s = sync2_q;

  // Next-state logic: synchroniser shift, start qualification, mid-bit
  // sampling of data/parity/stop, and the single-cycle result strobes.
  always_comb begin
    sync1_d     = rx;
    sync2_d     = sync1_q;
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // A held-low line must go high once before a new start is accepted.
        if (rx_s) begin
          armed_d = 1'b1;
        end
        if (armed_q && !rx_s) begin
          state_d  = S_START;
          os_cnt_d = 4'd0;
        end
      end

      S_START: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 4'd1;
          if (os_cnt_q == 4'd7) begin
            if (!rx_s) begin
              state_d   = S_DATA;
              os_cnt_d  = 4'd0;
              bit_cnt_d = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 4'd1;
          if (os_cnt_q == 4'd15) begin
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 4'd1;
          if (os_cnt_q == 4'd15) begin
            par_bad_d = ((^shift_q) ^ rx_s) != parity_odd;
            state_d   = S_STOP;
          end
        end
      end
`endif

      S_STOP: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 4'd1;
          if (os_cnt_q == 4'd15) begin
            state_d = S_IDLE;
            if (rx_s) begin
              rx_data_d = shift_q;
`ifdef UART_RX_PARITY_EN
              rx_valid_d   = !par_bad_q;
              parity_err_d = par_bad_q;
`else
              rx_valid_d = 1'b1;
`endif
            end else begin
              frame_err_d = 1'b1;
              armed_d     = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State registers; the synchroniser resets to the idle (high) line level.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      os_cnt_q    <= 4'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: randomized scenario bench for uart_rx_oversampled.
// A frame-level reference model predicts the strobe sequence and the
// rx_data value seen at each strobe; a monitor records what the DUT emits.
// Set UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx_oversampled;

  logic       clk    = 1'b0;
  logic       arst_n = 1'b1;
  logic       tick   = 1'b0;
  logic       rx     = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd = 1'b0;
  logic       parity_err;
`endif

  int n_vec = 0;
  int n_err = 0;
  int tp = 4;
  int busy_cycles = 0;
  int overlap = 0;
  int cyc = 0;

  // Observed strobes: kind 0 = rx_valid, 1 = frame_err, 2 = parity_err
  int         obs_kind[$];
  logic [7:0] obs_data[$];
  int         obs_cyc[$];
  // Expected strobes from the reference model
  int         exp_kind[$];
  logic [7:0] exp_data[$];
  logic [7:0] model_rx_data = 8'h00;

  uart_rx_oversampled #(.DATA_BITS(8)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .tick      (tick),
    .rx        (rx),
`ifdef UART_RX_PARITY_EN
    .parity_odd(parity_odd),
    .parity_err(parity_err),
`endif
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Oversample tick: one clk-wide pulse every tp clocks
  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (div >= tp - 1) begin
        div  = 0;
        tick = 1'b1;
      end else begin
        div  = div + 1;
        tick = 1'b0;
      end
    end
  end

  // Monitor: records every strobe cycle and accumulates busy time
  initial begin
    forever begin
      int pe;
      @(negedge clk);
      pe = 0;
`ifdef UART_RX_PARITY_EN
      pe = (parity_err === 1'b1) ? 1 : 0;
`endif
      if (arst_n === 1'b1) begin
        if ((rx_valid === 1'b1) + (frame_err === 1'b1) + pe > 1) overlap = overlap + 1;
        if (rx_valid === 1'b1) begin obs_kind.push_back(0); obs_data.push_back(rx_data); obs_cyc.push_back(cyc); end
        if (frame_err === 1'b1) begin obs_kind.push_back(1); obs_data.push_back(rx_data); obs_cyc.push_back(cyc); end
        if (pe == 1) begin obs_kind.push_back(2); obs_data.push_back(rx_data); obs_cyc.push_back(cyc); end
        if (busy === 1'b1) busy_cycles = busy_cycles + 1;
      end
    end
  end

  // Reference model: the outcome of one complete frame
  function automatic void model_frame(input logic [7:0] d, input logic stop, input logic par);
    logic perr;
    perr = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr = ((^d) ^ par) != parity_odd;
`endif
    if (!stop) begin
      exp_kind.push_back(1);
      exp_data.push_back(model_rx_data);
    end else begin
      model_rx_data = d;
      exp_kind.push_back(perr ? 2 : 0);
      exp_data.push_back(d);
    end
  endfunction

  function automatic logic good_par(input logic [7:0] d);
`ifdef UART_RX_PARITY_EN
    return (^d) ^ parity_odd;
`else
    return (^d);
`endif
  endfunction

  task automatic send_bit(input logic b);
    rx = b;
    repeat (16 * tp) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * 16 * tp) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    model_frame(d, stop, par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  task automatic clear_obs();
    obs_kind.delete(); obs_data.delete(); obs_cyc.delete();
    exp_kind.delete(); exp_data.delete();
    busy_cycles = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("[TB] FAIL reset_rx_data: got %h, required 00", rx_data); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rx_valid: got %b, required 0", rx_valid); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("[TB] FAIL reset_frame_err: got %b, required 0", frame_err); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    model_rx_data = 8'h00;
    idle_bits(2);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_single_frame();
    clear_obs();
    send_frame(8'h55, 1'b1, good_par(8'h55));
    idle_bits(1);
    n_vec++; if (obs_kind.size() !== exp_kind.size()) begin n_err++; $display("[TB] FAIL single_count: got %0d strobes, required %0d", obs_kind.size(), exp_kind.size()); end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      n_vec++;
      if (obs_kind[i] !== exp_kind[i] || obs_data[i] !== exp_data[i]) begin
        n_err++; $display("[TB] FAIL single_event%0d: got kind %0d data %h, required kind %0d data %h", i, obs_kind[i], obs_data[i], exp_kind[i], exp_data[i]);
      end
    end
    n_vec++;
    if (busy_cycles < 151 * tp || busy_cycles > 153 * tp) begin
      n_err++; $display("[TB] FAIL single_busy_len: got %0d clk, required %0d..%0d", busy_cycles, 151 * tp, 153 * tp);
    end
  endtask

  task automatic test_glitch();
    clear_obs();
    rx = 1'b0;
    repeat (4 * tp) @(negedge clk);
    idle_bits(2);
    n_vec++; if (obs_kind.size() !== 0) begin n_err++; $display("[TB] FAIL glitch_strobe: got %0d strobes, required 0", obs_kind.size()); end
    n_vec++;
    if (busy_cycles < 7 * tp || busy_cycles > 9 * tp) begin
      n_err++; $display("[TB] FAIL glitch_busy_len: got %0d clk, required %0d..%0d", busy_cycles, 7 * tp, 9 * tp);
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL glitch_idle: got busy %b, required 0", busy); end
  endtask

  task automatic test_frame_err();
    logic [7:0] d;
    clear_obs();
    send_frame(8'hA3, 1'b0, good_par(8'hA3));
    busy_cycles = 0;
    rx = 1'b0;
    repeat (3 * 16 * tp) @(negedge clk);
    n_vec++; if (busy_cycles !== 0) begin n_err++; $display("[TB] FAIL ferr_retrigger: got %0d busy clk on held-low line, required 0", busy_cycles); end
    idle_bits(1);
    d = 8'($urandom);
    send_frame(d, 1'b1, good_par(d));
    idle_bits(1);
    n_vec++; if (obs_kind.size() !== exp_kind.size()) begin n_err++; $display("[TB] FAIL ferr_count: got %0d strobes, required %0d", obs_kind.size(), exp_kind.size()); end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      n_vec++;
      if (obs_kind[i] !== exp_kind[i] || obs_data[i] !== exp_data[i]) begin
        n_err++; $display("[TB] FAIL ferr_event%0d: got kind %0d data %h, required kind %0d data %h", i, obs_kind[i], obs_data[i], exp_kind[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    clear_obs();
    send_frame(8'hA5, 1'b1, good_par(8'hA5));
    send_frame(8'h3C, 1'b1, good_par(8'h3C));
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1, good_par(d));
    end
    idle_bits(2);
    n_vec++; if (obs_kind.size() !== exp_kind.size()) begin n_err++; $display("[TB] FAIL b2b_count: got %0d strobes, required %0d", obs_kind.size(), exp_kind.size()); end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      n_vec++;
      if (obs_kind[i] !== exp_kind[i] || obs_data[i] !== exp_data[i]) begin
        n_err++; $display("[TB] FAIL b2b_event%0d: got kind %0d data %h, required kind %0d data %h", i, obs_kind[i], obs_data[i], exp_kind[i], exp_data[i]);
      end
    end
    if (obs_cyc.size() >= 2) begin
      n_vec++;
      if (obs_cyc[1] - obs_cyc[0] < 160 * tp - 2 || obs_cyc[1] - obs_cyc[0] > 160 * tp + 2) begin
        n_err++; $display("[TB] FAIL b2b_spacing: got %0d clk, required %0d", obs_cyc[1] - obs_cyc[0], 160 * tp);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    clear_obs();
    d = 8'hFF;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = 1'b1;
    repeat (8 * tp) @(negedge clk);
    arst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_busy: got %b, required 0", busy); end
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("[TB] FAIL midrst_rx_data: got %h, required 00", rx_data); end
    repeat (4) @(negedge clk);
    arst_n = 1'b1;
    model_rx_data = 8'h00;
    idle_bits(2);
    send_frame(8'h12, 1'b1, good_par(8'h12));
    idle_bits(2);
    n_vec++; if (obs_kind.size() !== exp_kind.size()) begin n_err++; $display("[TB] FAIL midrst_count: got %0d strobes, required %0d", obs_kind.size(), exp_kind.size()); end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      n_vec++;
      if (obs_kind[i] !== exp_kind[i] || obs_data[i] !== exp_data[i]) begin
        n_err++; $display("[TB] FAIL midrst_event%0d: got kind %0d data %h, required kind %0d data %h", i, obs_kind[i], obs_data[i], exp_kind[i], exp_data[i]);
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_obs();
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    send_frame(8'h07, 1'b1, 1'b0);
    idle_bits(1);
    parity_odd = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    idle_bits(1);
    parity_odd = 1'b0;
    n_vec++; if (obs_kind.size() !== exp_kind.size()) begin n_err++; $display("[TB] FAIL parity_count: got %0d strobes, required %0d", obs_kind.size(), exp_kind.size()); end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      n_vec++;
      if (obs_kind[i] !== exp_kind[i] || obs_data[i] !== exp_data[i]) begin
        n_err++; $display("[TB] FAIL parity_event%0d: got kind %0d data %h, required kind %0d data %h", i, obs_kind[i], obs_data[i], exp_kind[i], exp_data[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] d;
    logic       stop;
    logic       par;
    int         gap;
    clear_obs();
    overlap = 0;
    tp = int'($urandom_range(2, 6));
    idle_bits(1);
    for (int k = 0; k < 20; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      par  = ($urandom_range(0, 4) != 0) ? good_par(d) : ~good_par(d);
      gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(d, stop, par);
      if (gap > 0) idle_bits(gap);
    end
    idle_bits(2);
    n_vec++; if (obs_kind.size() !== exp_kind.size()) begin n_err++; $display("[TB] FAIL rand_count: got %0d strobes, required %0d (tp %0d)", obs_kind.size(), exp_kind.size(), tp); end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      n_vec++;
      if (obs_kind[i] !== exp_kind[i] || obs_data[i] !== exp_data[i]) begin
        n_err++; $display("[TB] FAIL rand_event%0d: got kind %0d data %h, required kind %0d data %h", i, obs_kind[i], obs_data[i], exp_kind[i], exp_data[i]);
      end
    end
    n_vec++; if (overlap !== 0) begin n_err++; $display("[TB] FAIL rand_overlap: got %0d cycles with two strobes, required 0", overlap); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL rand_idle: got busy %b, required 0", busy); end
    tp = 4;
  endtask

  initial begin
    $display("[TB] uart_rx_oversampled bench start");
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- UART receiver that consumes the 16x-oversampling `tick` from the baud rate generator.
- Synchronises the asynchronous `rx` line and detects start bits.
- Samples each bit at mid-point (tick 8 of 16) and assembles an LSB-first data word.
- Emits a one-cycle `rx_valid` strobe with the received word, or a `frame_err` strobe when the stop bit is bad.

Parameters:
- DATA_BITS, 8, number of data bits per frame; legal range 5..8.

Ports:
- clk  input  1  system clock.
- arst_n  input  1  asynchronous, active-low reset.
- tick  input  1  16x baud enable; one clk-wide pulse per oversample period.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  DATA_BITS  last received word; holds until the next frame completes.
- rx_valid  output  1  one-clk pulse: `rx_data` was updated with a good frame.
- frame_err  output  1  one-clk pulse: stop bit was sampled low.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset values:
  - `rx_data` = 0; `rx_valid` = 0; `frame_err` = 0; `busy` = 0.
  - State = IDLE; `armed` = 0.
  - Both synchroniser flops = 1.
- Reset takes effect immediately at any time, including mid-frame; the partial frame is discarded and no strobe is issued.
- Synchroniser: 2-flop chain on `rx` producing `rx_s`; adds 2 clk of latency. All logic below uses `rx_s` only.
- Internal counters: 4-bit `os_cnt` (oversample) and 3-bit `bit_cnt`. Both advance only on cycles where `tick` = 1; nothing moves when `tick` = 0.
- `armed` flag: set on any cycle with `rx_s` = 1 in IDLE. Prevents a held-low line (break or stuck low) from retriggering.
- FSM states and transitions:
  - IDLE: if `armed` and `rx_s` = 0, go to START with `os_cnt` = 0. Detection is evaluated every clk, not gated by `tick`.
  - START: on `tick`, `os_cnt`++. At the tick where `os_cnt` == 7 (8th tick), sample `rx_s`:
    - 0: go to DATA, `os_cnt` = 0, `bit_cnt` = 0.
    - 1: glitch; return to IDLE with no strobe.
  - DATA: on `tick`, `os_cnt`++. At the tick where `os_cnt` == 15 (16th tick after the previous sample):
    - Shift `rx_s` into the MSB of the shift register (right-shift, so the first bit lands at bit 0).
    - `bit_cnt`++; `os_cnt` wraps to 0.
    - After DATA_BITS samples, go to STOP (or PARITY when the optional feature is enabled).
  - STOP: at the 16th tick, sample `rx_s`:
    - 1: `rx_data` <= shift register, `rx_valid` = 1 on the next clk.
    - 0: `frame_err` = 1 on the next clk; `rx_data` unchanged; `armed` cleared.
    - Both cases return to IDLE.
- `rx_valid` and `frame_err` are never high together and are each exactly 1 clk wide.
- Back-to-back frames: the stop sample happens mid-stop-bit, so the FSM is in IDLE 8 ticks before the next start edge; no frame is lost.
- `busy` = (state != IDLE), registered.
- Changing the `tick` rate mid-frame is not supported; the result is undefined but must not lock up. Any state returns to IDLE within 1 frame.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds input `parity_odd` (1 bit; 0 = even, 1 = odd) and output `parity_err` (1-clk pulse, reset 0).
  - Adds a PARITY state between DATA and STOP, sampled at its 16th tick.
  - A parity mismatch latches an error. When the stop bit is good, this produces a `parity_err` pulse instead of `rx_valid`, in the same cycle `rx_valid` would have pulsed; `rx_data` is still updated.
  - A bad stop bit gives `frame_err` only.
- Undefined: no PARITY state, no extra ports; the frame is start + DATA_BITS + stop.

Test Plan:
- Tick period 651 clk (100 MHz, 9600 baud), send 0x55 with stop = 1 -> exactly one `rx_valid` pulse, `rx_data` = 0x55, `frame_err` never high, `busy` high for about 9.5 bit times.
- `rx` low for 4 ticks then high (glitch) -> no strobe, `busy` drops 8 ticks after the edge, FSM back in IDLE.
- Send 0xA3 with stop bit = 0, then hold `rx` low for 3 bit times -> one `frame_err` pulse, `rx_data` keeps its previous value, no second start detected until `rx` returns high.
- Back-to-back frames 0xA5, 0x3C with no idle gap -> two `rx_valid` pulses ~10 bit times apart carrying 0xA5 then 0x3C.
- Assert `arst_n` low during data bit 4 of 0xFF, release, then send 0x12 -> all outputs reset to 0 and no strobe from the aborted frame; the next strobe is `rx_valid` with `rx_data` = 0x12.
- UART_RX_PARITY_EN, `parity_odd` = 0: send 0x07 with parity bit 1 -> `rx_valid`, `rx_data` = 0x07. Send 0x07 with parity bit 0 -> `parity_err` pulse, no `rx_valid`.
